// File: rtl/audio_mix_limiter.sv
// Stereo PSG+PCM mixer: master gain with stepped ramp, 16-bit saturation,
// 24-bit DAC words, sticky clip flag and mute-complete indication.
module audio_mix_limiter #(
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next_sample,
  input  logic [15:0] psg_left,
  input  logic [15:0] psg_right,
  input  logic [15:0] pcm_left,
  input  logic [15:0] pcm_right,
  input  logic [3:0]  master_vol,
  input  logic        mute,
  input  logic        clip_clear,
  output logic [23:0] left_data,
  output logic [23:0] right_data,
  output logic        clip,
  output logic        mute_done
);

  // state  | meaning
  // MUTED  | gain held at 0
  // UP     | gain stepping toward a higher target
  // STEADY | gain equals a nonzero target
  // DOWN   | gain stepping toward a lower target
  typedef enum logic [1:0] {MUTED, UP, STEADY, DOWN} state_t;

  localparam logic [4:0] STEP = 5'(RAMP_STEP);

  state_t      state_q, state_d;
  logic [4:0]  gain_q, gain_d;
  logic [4:0]  target, up_diff, dn_diff, up_gain, dn_gain;

  logic [15:0] psg_l_q, psg_l_d, psg_r_q, psg_r_d;
  logic [15:0] pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
  logic [4:0]  g0_q, g0_d, g1_q, g1_d;
  logic        v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic [16:0] sum_l_q, sum_l_d, sum_r_q, sum_r_d;
  logic [15:0] sat_l_q, sat_l_d, sat_r_q, sat_r_d;
  logic [16:0] res_l, res_r;
  logic [23:0] left_data_q, left_data_d, right_data_q, right_data_d;
  logic        clip_q, clip_d, mute_done_q, mute_done_d;

  // Returns {saturated, value}; scaling is floor((sum*g)/16).
  function automatic logic [16:0] scale_sat(input logic [16:0] sum, input logic [4:0] g);
    logic signed [21:0] prod;
    logic signed [21:0] scaled;
    logic [16:0]        res;
    prod   = $signed({{5{sum[16]}}, sum}) * $signed({17'd0, g});
    scaled = prod >>> 4;
    if (scaled > 22'sd32767)
      res = {1'b1, 16'h7FFF};
    else if (scaled < -22'sd32768)
      res = {1'b1, 16'h8000};
    else
      res = {1'b0, scaled[15:0]};
    return res;
  endfunction

  always_comb begin
    target  = mute ? 5'd0 : ({1'b0, master_vol} + 5'd1);
    up_diff = target - gain_q;
    dn_diff = gain_q - target;
    up_gain = gain_q + ((up_diff < STEP) ? up_diff : STEP);
    dn_gain = gain_q - ((dn_diff < STEP) ? dn_diff : STEP);
    state_d = state_q;
    gain_d  = gain_q;
    if (next_sample) begin
      case (state_q)
        MUTED: begin
          if (target > gain_q) begin
            gain_d  = up_gain;
            state_d = (up_gain == target) ? STEADY : UP;
          end
        end
        default: begin
          if (target > gain_q) begin
            gain_d  = up_gain;
            state_d = (up_gain == target) ? STEADY : UP;
          end else if (target < gain_q) begin
            gain_d  = dn_gain;
            if (dn_gain == 5'd0)
              state_d = MUTED;
            else if (dn_gain == target)
              state_d = STEADY;
            else
              state_d = DOWN;
          end else begin
            state_d = (gain_q == 5'd0) ? MUTED : STEADY;
          end
        end
      endcase
    end
  end

  // Capture uses the pre-update gain, so a sample never sees its own strobe's step.
  always_comb begin
    psg_l_d = next_sample ? psg_left  : psg_l_q;
    psg_r_d = next_sample ? psg_right : psg_r_q;
    pcm_l_d = next_sample ? pcm_left  : pcm_l_q;
    pcm_r_d = next_sample ? pcm_right : pcm_r_q;
    g0_d    = next_sample ? gain_q    : g0_q;
    v0_d    = next_sample;

    sum_l_d = {psg_l_q[15], psg_l_q} + {pcm_l_q[15], pcm_l_q};
    sum_r_d = {psg_r_q[15], psg_r_q} + {pcm_r_q[15], pcm_r_q};
    g1_d    = g0_q;
    v1_d    = v0_q;

    res_l   = scale_sat(sum_l_q, g1_q);
    res_r   = scale_sat(sum_r_q, g1_q);
    sat_l_d = v1_q ? res_l[15:0] : sat_l_q;
    sat_r_d = v1_q ? res_r[15:0] : sat_r_q;
    v2_d    = v1_q;
    clip_d  = (clip_q & ~clip_clear) | (v1_q & (res_l[16] | res_r[16]));

    left_data_d  = v2_q ? {sat_l_q, 8'h00} : left_data_q;
    right_data_d = v2_q ? {sat_r_q, 8'h00} : right_data_q;
    mute_done_d  = mute && (gain_q == 5'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MUTED;
      gain_q       <= '0;
      psg_l_q      <= '0;
      psg_r_q      <= '0;
      pcm_l_q      <= '0;
      pcm_r_q      <= '0;
      g0_q         <= '0;
      v0_q         <= 1'b0;
      sum_l_q      <= '0;
      sum_r_q      <= '0;
      g1_q         <= '0;
      v1_q         <= 1'b0;
      sat_l_q      <= '0;
      sat_r_q      <= '0;
      v2_q         <= 1'b0;
      left_data_q  <= '0;
      right_data_q <= '0;
      clip_q       <= 1'b0;
      mute_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gain_q       <= gain_d;
      psg_l_q      <= psg_l_d;
      psg_r_q      <= psg_r_d;
      pcm_l_q      <= pcm_l_d;
      pcm_r_q      <= pcm_r_d;
      g0_q         <= g0_d;
      v0_q         <= v0_d;
      sum_l_q      <= sum_l_d;
      sum_r_q      <= sum_r_d;
      g1_q         <= g1_d;
      v1_q         <= v1_d;
      sat_l_q      <= sat_l_d;
      sat_r_q      <= sat_r_d;
      v2_q         <= v2_d;
      left_data_q  <= left_data_d;
      right_data_q <= right_data_d;
      clip_q       <= clip_d;
      mute_done_q  <= mute_done_d;
    end
  end

  assign left_data  = left_data_q;
  assign right_data = right_data_q;
  assign clip       = clip_q;
  assign mute_done  = mute_done_q;

endmodule

// File: tb/tb_audio_mix_limiter.sv
// Directed bench for audio_mix_limiter: ramp, latency, saturation, clip,
// mute fade, volume reversal, rounding and async reset.
module tb_audio_mix_limiter;

  logic        clk;
  logic        rst;
  logic        next_sample;
  logic [15:0] psg_left, psg_right, pcm_left, pcm_right;
  logic [3:0]  master_vol;
  logic        mute;
  logic        clip_clear;
  logic [23:0] left_data, right_data;
  logic        clip, mute_done;

  int checks = 0;
  int errors = 0;

  audio_mix_limiter #(.RAMP_STEP(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .next_sample (next_sample),
    .psg_left    (psg_left),
    .psg_right   (psg_right),
    .pcm_left    (pcm_left),
    .pcm_right   (pcm_right),
    .master_vol  (master_vol),
    .mute        (mute),
    .clip_clear  (clip_clear),
    .left_data   (left_data),
    .right_data  (right_data),
    .clip        (clip),
    .mute_done   (mute_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected 24-bit DAC word for a channel sum at a given gain.
  function automatic logic [31:0] mixw(input int sum, input int g);
    int p;
    p = (sum * g) >>> 4;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return {8'h00, p[15:0], 8'h00};
  endfunction

  task automatic strobe();
    @(negedge clk) next_sample = 1'b1;
    @(negedge clk) next_sample = 1'b0;
  endtask

  task automatic sample();
    strobe();
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk) clip_clear = 1'b1;
    @(negedge clk) clip_clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; next_sample = 1'b0; clip_clear = 1'b0; mute = 1'b0;
    master_vol = 4'd0;
    psg_left = '0; psg_right = '0; pcm_left = '0; pcm_right = '0;
    repeat (2) @(negedge clk);
    check("rst_left", 32'(left_data), 32'h0);
    check("rst_right", 32'(right_data), 32'h0);
    check("rst_clip", 32'(clip), 32'h0);
    check("rst_mute_done", 32'(mute_done), 32'h0);
    rst = 1'b0;

    // Unity ramp and latency
    master_vol = 4'd15; psg_left = 16'd1000; pcm_left = 16'd2000;
    for (int k = 1; k <= 16; k++) begin
      sample();
      check("ramp_up", 32'(left_data), mixw(3000, k - 1));
    end
    strobe();
    repeat (2) @(negedge clk);
    check("latency_hold", 32'(left_data), 32'h0AFC00);
    @(negedge clk);
    check("unity_left", 32'(left_data), 32'h0BB800);
    check("unity_right", 32'(right_data), 32'h0);
    check("unity_clip", 32'(clip), 32'h0);

    // Saturation and clip flag
    psg_left = 16'h7000; pcm_left = 16'h7000;
    sample();
    check("sat_pos", 32'(left_data), 32'h7FFF00);
    check("sat_pos_clip", 32'(clip), 32'h1);
    pulse_clear();
    check("clip_cleared", 32'(clip), 32'h0);
    psg_left = 16'h8000; pcm_left = 16'h8000;
    sample();
    check("sat_neg", 32'(left_data), 32'h800000);
    check("sat_neg_clip", 32'(clip), 32'h1);
    pulse_clear();
    check("clip_cleared2", 32'(clip), 32'h0);
    psg_left = 16'h7000; pcm_left = 16'h7000;
    strobe();
    @(negedge clk) clip_clear = 1'b1;
    @(negedge clk) clip_clear = 1'b0;
    check("clip_set_wins", 32'(clip), 32'h1);
    @(negedge clk);
    check("sat_pos2", 32'(left_data), 32'h7FFF00);
    pulse_clear();

    // Mute fade
    psg_left = 16'd1000; pcm_left = 16'd2000; mute = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      sample();
      check("fade", 32'(left_data), mixw(3000, 17 - k));
      if (k == 9)  check("fade_half", 32'(left_data), 32'h05DC00);
      if (k == 15) check("mute_done_early", 32'(mute_done), 32'h0);
      if (k == 16) check("mute_done_set", 32'(mute_done), 32'h1);
    end
    check("fade_zero", 32'(left_data), 32'h0);
    @(negedge clk) mute = 1'b0;
    @(negedge clk);
    check("mute_done_clr", 32'(mute_done), 32'h0);
    sample();
    check("restart_g0", 32'(left_data), 32'h0);
    sample();
    check("restart_g1", 32'(left_data), 32'h00BB00);

    // Volume change and reversal; sum 16 makes output equal to gain
    psg_left = 16'd16; pcm_left = 16'd0;
    repeat (14) sample();
    master_vol = 4'd7;
    for (int k = 1; k <= 10; k++) begin
      sample();
      check("vol_down", 32'(left_data), mixw(16, (17 - k) > 8 ? (17 - k) : 8));
    end
    master_vol = 4'd15;
    repeat (8) sample();
    check("vol_up16", 32'(left_data), mixw(16, 15));
    master_vol = 4'd7;
    repeat (4) sample();
    check("down_to12", 32'(left_data), mixw(16, 13));
    master_vol = 4'd15;
    for (int k = 1; k <= 4; k++) begin
      sample();
      check("reversal", 32'(left_data), mixw(16, 11 + k));
    end

    // Rounding and sign at gain 8
    master_vol = 4'd7;
    repeat (8) sample();
    psg_left = 16'hFFFF; pcm_left = 16'd0; psg_right = 16'd1; pcm_right = 16'd0;
    sample();
    check("floor_neg1", 32'(left_data), 32'hFFFF00);
    check("floor_pos1", 32'(right_data), 32'h0);
    psg_left = 16'd1000; pcm_left = 16'd2000; psg_right = 16'hFC18; pcm_right = 16'hF830;
    sample();
    check("indep_left", 32'(left_data), 32'h05DC00);
    check("indep_right", 32'(right_data), 32'hFA2400);

    // Async reset mid-pipeline
    master_vol = 4'd15; psg_left = 16'h7000; pcm_left = 16'h7000;
    repeat (9) sample();
    check("pre_rst_left", 32'(left_data), 32'h7FFF00);
    check("pre_rst_right", 32'(right_data), mixw(-3000, 16));
    check("pre_rst_clip", 32'(clip), 32'h1);
    psg_left = 16'd1000; pcm_left = 16'd2000;
    strobe();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_left", 32'(left_data), 32'h0);
    check("arst_right", 32'(right_data), 32'h0);
    check("arst_clip", 32'(clip), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("no_stale", 32'(left_data), 32'h0);
    sample();
    check("post_rst_g0", 32'(left_data), 32'h0);
    sample();
    check("post_rst_g1_l", 32'(left_data), 32'h00BB00);
    check("post_rst_g1_r", 32'(right_data), 32'hFF4400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
